// File: rtl/key_event_pkg.sv
// Shared types and default timing constants for the push-button event generator.
// Also provides a small constant helper used to size the hold counter.
package key_event_pkg;

   typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} key_state_t;

   localparam int DEF_LONG_CYCLES   = 50_000_000;
   localparam int DEF_REPEAT_CYCLES = 10_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; RST_VAL selects the
// level both flops take during reset so the output is benign out of reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstN,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         meta_reg <= RST_VAL;
         sync_reg <= RST_VAL;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/key_event_gen.sv
// Classifies a debounced active-low button into press/short/long/release pulses.
// Define KEY_REPEAT_EN to enable periodic repeat pulses while the key is held long.
module key_event_gen
   import key_event_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
   input  logic clk,
   input  logic rstN,
   input  logic btn_in,
   output logic pressed_o,
   output logic press_pulse_o,
   output logic short_pulse_o,
   output logic long_pulse_o,
   output logic release_pulse_o,
   output logic repeat_pulse_o
);

   localparam int CNT_W = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES);

   logic             sync_q;
   logic             btn_s;
   key_state_t       state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             pressed_next, press_next, short_next, long_next, release_next;

   // Resets to released so a reset never fabricates a press.
   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rstN (rstN),
      .d    (btn_in),
      .q    (sync_q)
   );

   assign btn_s = ~sync_q;

`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_CYCLES - 1);
   logic repeat_next;
   logic repeat_reg;
`endif

   // The counter holds the number of cycles held so far, press cycle included,
   // so the long pulse lands exactly LONG_CYCLES cycles after the press pulse.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      press_next   = 1'b0;
      short_next   = 1'b0;
      long_next    = 1'b0;
      release_next = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_next  = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (btn_s) begin
               state_next = PRESSED;
               cnt_next   = CNT_W'(1);
               press_next = 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_next   = IDLE;
               cnt_next     = '0;
               short_next   = 1'b1;
               release_next = 1'b1;
            end else if (cnt_reg == LONG_TERM) begin
               state_next = LONG_HELD;
               cnt_next   = '0;
               long_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         LONG_HELD: begin
            if (!btn_s) begin
               state_next   = IDLE;
               cnt_next     = '0;
               release_next = 1'b1;
            end else begin
`ifdef KEY_REPEAT_EN
               if (cnt_reg == REP_TERM) begin
                  cnt_next    = '0;
                  repeat_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
`else
               cnt_next = '0;
`endif
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
      pressed_next = (state_next != IDLE);
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         pressed_o       <= 1'b0;
         press_pulse_o   <= 1'b0;
         short_pulse_o   <= 1'b0;
         long_pulse_o    <= 1'b0;
         release_pulse_o <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         pressed_o       <= pressed_next;
         press_pulse_o   <= press_next;
         short_pulse_o   <= short_next;
         long_pulse_o    <= long_next;
         release_pulse_o <= release_next;
      end
   end

`ifdef KEY_REPEAT_EN
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         repeat_reg <= 1'b0;
      end else begin
         repeat_reg <= repeat_next;
      end
   end

   assign repeat_pulse_o = repeat_reg;
`else
   assign repeat_pulse_o = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG_CYCLES=20, REPEAT_CYCLES=5;
// expectations follow KEY_REPEAT_EN when it is defined for the build.
module tb_key_event_gen;

   localparam int L = 20;
   localparam int R = 5;

   logic clk = 1'b0;
   logic rstN = 1'b0;
   logic btn_in = 1'b1;
   logic pressed_o, press_pulse_o, short_pulse_o, long_pulse_o, release_pulse_o, repeat_pulse_o;

   key_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
      .clk             (clk),
      .rstN            (rstN),
      .btn_in          (btn_in),
      .pressed_o       (pressed_o),
      .press_pulse_o   (press_pulse_o),
      .short_pulse_o   (short_pulse_o),
      .long_pulse_o    (long_pulse_o),
      .release_pulse_o (release_pulse_o),
      .repeat_pulse_o  (repeat_pulse_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   // Event log, sampled on the falling edge.
   int press_n, short_n, long_n, rel_n, rep_n, held_n, excl_n;
   int press_at, short_at, long_at, rel_at;
   int rep_at [4];
   logic [4:0] prev_pulses = '0;

   always @(negedge clk) begin
      logic [4:0] p;
      p = {press_pulse_o, short_pulse_o, long_pulse_o, release_pulse_o, repeat_pulse_o};
      if (press_pulse_o)   begin press_n++; press_at = cyc; end
      if (short_pulse_o)   begin short_n++; short_at = cyc; end
      if (long_pulse_o)    begin long_n++;  long_at  = cyc; end
      if (release_pulse_o) begin rel_n++;   rel_at   = cyc; end
      if (repeat_pulse_o) begin
         if (rep_n < 4) rep_at[rep_n] = cyc;
         rep_n++;
      end
      if (pressed_o) held_n++;
      // Only short+release may coincide, and no pulse may last two cycles.
      if ((int'(press_pulse_o) + int'(long_pulse_o) + int'(release_pulse_o) + int'(repeat_pulse_o)) > 1)
         excl_n++;
      if (short_pulse_o && !release_pulse_o) excl_n++;
      if ((p & prev_pulses) != '0) excl_n++;
      prev_pulses = p;
   end

   task automatic clear_log();
      press_n = 0; short_n = 0; long_n = 0; rel_n = 0; rep_n = 0; held_n = 0; excl_n = 0;
      press_at = -1; short_at = -1; long_at = -1; rel_at = -1;
      for (int i = 0; i < 4; i++) rep_at[i] = -1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] out_vec();
      return {26'd0, pressed_o, press_pulse_o, short_pulse_o, long_pulse_o, release_pulse_o, repeat_pulse_o};
   endfunction

   // Hold the button for hold_cycles, then release and let the pipeline drain.
   task automatic press_for(input int hold_cycles, output int d);
      clear_log();
      d = cyc;
      btn_in = 1'b0;
      wait_cycles(hold_cycles);
      btn_in = 1'b1;
      wait_cycles(10);
   endtask

   int d;

   initial begin
      clear_log();
      #2;
      check_eq("reset_outputs", out_vec(), 32'd0);
      wait_cycles(3);
      rstN = 1'b1;

      clear_log();
      wait_cycles(100);
      check_eq("idle_outputs_quiet", press_n + short_n + long_n + rel_n + rep_n + held_n, 0);
      $display("idle: 100 cycles released, events=%0d", press_n + rel_n + held_n);

      press_for(10, d);
      check_eq("short_press_at", press_at, d + 3);
      check_eq("short_short_at", short_at, d + 13);
      check_eq("short_release_at", rel_at, d + 13);
      check_eq("short_long_count", long_n, 0);
      check_eq("short_held_cycles", held_n, 10);
      check_eq("short_pulse_counts", {press_n[7:0], short_n[7:0], rel_n[7:0], excl_n[7:0]}, 32'h01010100);
      $display("short: press@%0d short@%0d release@%0d held=%0d", press_at - d, short_at - d, rel_at - d, held_n);

      press_for(40, d);
      check_eq("long_press_at", press_at, d + 3);
      check_eq("long_long_at", long_at, d + 3 + L);
      check_eq("long_release_at", rel_at, d + 43);
      check_eq("long_short_count", short_n, 0);
      check_eq("long_held_cycles", held_n, 40);
      check_eq("long_exclusive", excl_n, 0);
`ifdef KEY_REPEAT_EN
      check_eq("repeat_count", rep_n, 3);
      check_eq("repeat_at_0", rep_at[0], d + 3 + L + R);
      check_eq("repeat_at_1", rep_at[1], d + 3 + L + 2 * R);
      check_eq("repeat_at_2", rep_at[2], d + 3 + L + 3 * R);
`else
      check_eq("repeat_count", rep_n, 0);
`endif
      $display("long: press@%0d long@%0d release@%0d repeats=%0d", press_at - d, long_at - d, rel_at - d, rep_n);

      press_for(20, d);
      check_eq("bound20_short_at", short_at, d + 23);
      check_eq("bound20_release_at", rel_at, d + 23);
      check_eq("bound20_long_count", long_n, 0);
      $display("boundary hold=20: short=%0d long=%0d", short_n, long_n);

      press_for(21, d);
      check_eq("bound21_long_at", long_at, d + 23);
      check_eq("bound21_short_count", short_n, 0);
      check_eq("bound21_release_at", rel_at, d + 24);
      $display("boundary hold=21: short=%0d long=%0d", short_n, long_n);

      clear_log();
      d = cyc;
      btn_in = 1'b0;
      wait_cycles(14);
      check_eq("midhold_pressed", {31'd0, pressed_o}, 32'd1);
      rstN = 1'b0;
      #1;
      check_eq("midhold_reset_outputs", out_vec(), 32'd0);
      wait_cycles(3);
      clear_log();
      d = cyc;
      rstN = 1'b1;
      wait_cycles(30);
      btn_in = 1'b1;
      wait_cycles(10);
      check_eq("rst_repress_at", press_at, d + 3);
      check_eq("rst_long_at", long_at, d + 3 + L);
      check_eq("rst_release_at", rel_at, d + 33);
      check_eq("rst_exclusive", excl_n, 0);
      $display("reset mid-hold: press@%0d long@%0d release@%0d", press_at - d, long_at - d, rel_at - d);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
